// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL scheduler state encoding and phase-length helpers.
// Contents:
//   scl_state_t   - SCL scheduler states (IDLE, LOW, WAIT_HIGH, HIGH)
//   calc_high_cyc - SCL high-phase length in clk cycles
//   calc_low_cyc  - SCL low-phase length in clk cycles
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    WAIT_HIGH = 2'd2,
    HIGH      = 2'd3
  } scl_state_t;

  // High phase: DUTY percent of the SCL period, rounded down.
  function automatic int unsigned calc_high_cyc(input int unsigned clk_khz,
                                                input int unsigned scl_khz,
                                                input int unsigned duty);
    int unsigned period;
    period = clk_khz / scl_khz;
    return (period * duty) / 100;
  endfunction

  // Low phase: whatever remains of the period, so low + high == period.
  function automatic int unsigned calc_low_cyc(input int unsigned clk_khz,
                                               input int unsigned scl_khz,
                                               input int unsigned duty);
    int unsigned period;
    period = clk_khz / scl_khz;
    return period - calc_high_cyc(clk_khz, scl_khz, duty);
  endfunction

endpackage

// File: rtl/i2c_scl_sched_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input; resets to 1 (idle bus level).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_d        - asynchronous input
//   o_q        - synchronized output (2 clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/i2c_scl_sched.sv
// SCL timing scheduler for the I2C master: generates SCL low/high phases with a
// cycle counter, honours slave clock stretching and emits one-cycle phase strobes.
// Optional macro I2C_SCL_STRETCH_TIMEOUT_EN enables the stretch timeout.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   en         - request SCL clocking (sampled in IDLE and on the last HIGH cycle)
//   scl_i      - SCL pad input (asynchronous)
//   scl_oe     - 1 = drive SCL low, 0 = release
//   fall_stb   - SCL driven low this cycle
//   chg_stb    - mid-low, SDA may change
//   rise_stb   - SCL seen high
//   smp_stb    - mid-high, sample SDA
//   done       - clocking finished, SCL left high
//   busy       - state != IDLE
//   stretched  - SCL released but still held low externally
//   timeout    - stretch timeout pulse (0 without the macro)
module i2c_scl_sched
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ = 100000,
  parameter int unsigned SCL_FREQ_KHZ = 100,
  parameter int unsigned DUTY         = 50,
  parameter int unsigned TIMEOUT_CYC  = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic scl_i,
  output logic scl_oe,
  output logic fall_stb,
  output logic chg_stb,
  output logic rise_stb,
  output logic smp_stb,
  output logic done,
  output logic busy,
  output logic stretched,
  output logic timeout
);

  localparam int unsigned PERIOD   = CLK_FREQ_KHZ / SCL_FREQ_KHZ;
  localparam int unsigned HIGH_CYC = calc_high_cyc(CLK_FREQ_KHZ, SCL_FREQ_KHZ, DUTY);
  localparam int unsigned LOW_CYC  = calc_low_cyc(CLK_FREQ_KHZ, SCL_FREQ_KHZ, DUTY);
  localparam int unsigned CW       = $clog2(PERIOD) + 1;

  localparam logic [CW-1:0] LOW_MID   = CW'(LOW_CYC / 2);
  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] HIGH_MID  = CW'(HIGH_CYC / 2);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYC - 1);

  // Elaboration guards on phase lengths and timeout.
  if (LOW_CYC < 4 || HIGH_CYC < 4) begin : g_bad_phase
    $error("i2c_scl_sched: LOW_CYC and HIGH_CYC must both be >= 4");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("i2c_scl_sched: TIMEOUT_CYC must be >= 2");
  end

  scl_state_t    r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          r_scl_oe, w_nxt_scl_oe;
  logic          r_fall, w_nxt_fall;
  logic          r_chg, w_nxt_chg;
  logic          r_rise, w_nxt_rise;
  logic          r_smp, w_nxt_smp;
  logic          r_done, w_nxt_done;
  logic          r_busy, w_nxt_busy;
  logic          r_stretched, w_nxt_stretched;
  logic          r_timeout, w_nxt_timeout;
  logic          w_scl_s;
  logic          w_to_hit;

  // SCL pad synchronizer.
  sync_2ff u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (scl_i),
    .o_q   (w_scl_s)
  );

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] r_scnt;

  // Stretch counter: counts consecutive WAIT_HIGH cycles, cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scnt <= '0;
    end else if (r_state == WAIT_HIGH && w_nxt_state == WAIT_HIGH) begin
      r_scnt <= r_scnt + TW'(1);
    end else begin
      r_scnt <= '0;
    end
  end

  assign w_to_hit = (r_state == WAIT_HIGH) && (r_scnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_scl_oe    <= 1'b0;
      r_fall      <= 1'b0;
      r_chg       <= 1'b0;
      r_rise      <= 1'b0;
      r_smp       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_stretched <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_scl_oe    <= w_nxt_scl_oe;
      r_fall      <= w_nxt_fall;
      r_chg       <= w_nxt_chg;
      r_rise      <= w_nxt_rise;
      r_smp       <= w_nxt_smp;
      r_done      <= w_nxt_done;
      r_busy      <= w_nxt_busy;
      r_stretched <= w_nxt_stretched;
      r_timeout   <= w_nxt_timeout;
    end
  end

  // Next-state and next-output logic. Strobes are decoded from the next count
  // so they appear in the cycle whose count matches the phase point.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_scl_oe    = r_scl_oe;
    w_nxt_fall      = 1'b0;
    w_nxt_chg       = 1'b0;
    w_nxt_rise      = 1'b0;
    w_nxt_smp       = 1'b0;
    w_nxt_done      = 1'b0;
    w_nxt_stretched = 1'b0;
    w_nxt_timeout   = 1'b0;

    case (r_state)
      IDLE: begin
        if (en) begin
          w_nxt_state  = LOW;
          w_nxt_cnt    = '0;
          w_nxt_scl_oe = 1'b1;
          w_nxt_fall   = 1'b1;
        end
      end
      LOW: begin
        w_nxt_cnt = r_cnt + CW'(1);
        w_nxt_chg = (r_cnt + CW'(1)) == LOW_MID;
        if (r_cnt == LOW_LAST) begin
          w_nxt_state  = WAIT_HIGH;
          w_nxt_cnt    = '0;
          w_nxt_scl_oe = 1'b0;
        end
      end
      WAIT_HIGH: begin
        if (w_scl_s) begin
          w_nxt_state = HIGH;
          w_nxt_cnt   = '0;
          w_nxt_rise  = 1'b1;
        end else if (w_to_hit) begin
          w_nxt_state   = IDLE;
          w_nxt_scl_oe  = 1'b0;
          w_nxt_timeout = 1'b1;
        end else begin
          // Registered, so it first shows in the second WAIT_HIGH cycle.
          w_nxt_stretched = 1'b1;
        end
      end
      HIGH: begin
        w_nxt_cnt = r_cnt + CW'(1);
        w_nxt_smp = (r_cnt + CW'(1)) == HIGH_MID;
        if (r_cnt == HIGH_LAST) begin
          w_nxt_cnt = '0;
          if (en) begin
            w_nxt_state  = LOW;
            w_nxt_scl_oe = 1'b1;
            w_nxt_fall   = 1'b1;
          end else begin
            w_nxt_state  = IDLE;
            w_nxt_scl_oe = 1'b0;
            w_nxt_done   = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state  = IDLE;
        w_nxt_cnt    = '0;
        w_nxt_scl_oe = 1'b0;
      end
    endcase

    w_nxt_busy = (w_nxt_state != IDLE);
  end

  assign scl_oe    = r_scl_oe;
  assign fall_stb  = r_fall;
  assign chg_stb   = r_chg;
  assign rise_stb  = r_rise;
  assign smp_stb   = r_smp;
  assign done      = r_done;
  assign busy      = r_busy;
  assign stretched = r_stretched;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_i2c_scl_sched.sv
// Self-checking bench for i2c_scl_sched (PERIOD=100, LOW=50, HIGH=50).
// Expected strobe events are queued with their cycle numbers as stimulus is
// applied; a negedge monitor pops and compares each strobe the DUT emits.
module tb_i2c_scl_sched;

  localparam int L_CYC = 50;           // low phase
  localparam int H_CYC = 50;           // high phase
  localparam int LAT   = 3;            // release -> rise_stb (2 sync flops + register)
  localparam int TO    = 1000;

  localparam int EV_FALL = 0, EV_CHG = 1, EV_RISE = 2, EV_SMP = 3, EV_DONE = 4, EV_TO = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic force_low = 1'b0;
  logic scl_i;
  logic scl_oe, fall_stb, chg_stb, rise_stb, smp_stb, done, busy, stretched, timeout;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  assign scl_i = force_low ? 1'b0 : ~scl_oe;

  i2c_scl_sched #(
    .CLK_FREQ_KHZ (100000),
    .SCL_FREQ_KHZ (1000),
    .DUTY         (50),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .scl_i     (scl_i),
    .scl_oe    (scl_oe),
    .fall_stb  (fall_stb),
    .chg_stb   (chg_stb),
    .rise_stb  (rise_stb),
    .smp_stb   (smp_stb),
    .done      (done),
    .busy      (busy),
    .stretched (stretched),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // One SCL period starting with fall_stb at cycle f, released without stretching.
  task automatic push_period(input int f, input bit last);
    push(EV_FALL, f);
    push(EV_CHG, f + L_CYC / 2);
    push(EV_RISE, f + L_CYC + LAT);
    push(EV_SMP, f + L_CYC + LAT + H_CYC / 2);
    if (last) push(EV_DONE, f + L_CYC + LAT + H_CYC);
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) check("wait_target_passed", 64'(cyc), 64'(t));
    while (cyc < t) @(negedge clk);
  endtask

  // Encode event as kind*1e6 + cycle for a single comparison.
  task automatic see(input int kind, input logic s);
    ev_t e;
    if (s === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(kind * 1000000 + cyc), 64'(-1));
      end else begin
        e = exp_q.pop_front();
        check("strobe", 64'(kind * 1000000 + cyc), 64'(e.kind * 1000000 + e.at));
      end
    end
  endtask

  always @(negedge clk) begin
    see(EV_FALL, fall_stb);
    see(EV_CHG, chg_stb);
    see(EV_RISE, rise_stb);
    see(EV_SMP, smp_stb);
    see(EV_DONE, done);
    see(EV_TO, timeout);
  end

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;

    // Reset held with en=1.
    repeat (5) @(negedge clk);
    check("rst_scl_oe", 64'(scl_oe), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stretched", 64'(stretched), 64'(0));
    check("rst_strobes", 64'({fall_stb, chg_stb, rise_stb, smp_stb, done, timeout}), 64'(0));

    // Release with en=0: stay idle.
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_scl_oe", 64'(scl_oe), 64'(0));

    // Three periods; en dropped 20 cycles into the third one.
    en = 1'b1;
    f  = cyc + 1;
    push_period(f, 1'b0);
    push_period(f + 103, 1'b0);
    push_period(f + 206, 1'b1);
    wait_cyc(f);
    check("p0_busy", 64'(busy), 64'(1));
    check("p0_oe_start", 64'(scl_oe), 64'(1));
    wait_cyc(f + L_CYC - 1);
    check("p0_oe_last_low", 64'(scl_oe), 64'(1));
    wait_cyc(f + L_CYC);
    check("p0_oe_release", 64'(scl_oe), 64'(0));
    wait_cyc(f + 103 + L_CYC - 1);
    check("p1_oe_last_low", 64'(scl_oe), 64'(1));
    wait_cyc(f + 103 + L_CYC);
    check("p1_oe_release", 64'(scl_oe), 64'(0));
    wait_cyc(f + 206 + 20);
    en = 1'b0;
    wait_cyc(f + 309);
    check("stop_busy", 64'(busy), 64'(0));
    check("stop_scl_oe", 64'(scl_oe), 64'(0));
    repeat (200) @(negedge clk);
    check("stop_queue_empty", 64'(exp_q.size()), 64'(0));

    // Stretch: scl held low 200 cycles after release.
    force_low = 1'b1;
    en = 1'b1;
    f  = cyc + 1;
    push(EV_FALL, f);
    push(EV_CHG, f + 25);
    push(EV_RISE, f + 250 + LAT);
    push(EV_SMP, f + 250 + LAT + H_CYC / 2);
    push(EV_DONE, f + 250 + LAT + H_CYC);
    wait_cyc(f + 200);
    check("str_stretched", 64'(stretched), 64'(1));
    check("str_scl_oe", 64'(scl_oe), 64'(0));
    check("str_busy", 64'(busy), 64'(1));
    wait_cyc(f + 250);
    force_low = 1'b0;
    en = 1'b0;
    wait_cyc(f + 260);
    check("str_cleared", 64'(stretched), 64'(0));
    wait_cyc(f + 304);
    check("str_end_busy", 64'(busy), 64'(0));
    check("str_queue_empty", 64'(exp_q.size()), 64'(0));

    // Stuck-low SCL: timeout with the macro, indefinite wait without.
    force_low = 1'b1;
    en = 1'b1;
    f  = cyc + 1;
    push(EV_FALL, f);
    push(EV_CHG, f + 25);
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    push(EV_TO, f + L_CYC + TO);
    wait_cyc(f + 10);
    en = 1'b0;
    wait_cyc(f + L_CYC + TO + 1);
    check("to_busy", 64'(busy), 64'(0));
    check("to_scl_oe", 64'(scl_oe), 64'(0));
    repeat (50) @(negedge clk);
    force_low = 1'b0;
    repeat (20) @(negedge clk);
    check("to_queue_empty", 64'(exp_q.size()), 64'(0));
`else
    wait_cyc(f + 10);
    en = 1'b0;
    wait_cyc(f + 1100);
    check("nto_busy", 64'(busy), 64'(1));
    check("nto_stretched", 64'(stretched), 64'(1));
    push(EV_RISE, f + 1100 + LAT);
    push(EV_SMP, f + 1100 + LAT + H_CYC / 2);
    push(EV_DONE, f + 1100 + LAT + H_CYC);
    force_low = 1'b0;
    wait_cyc(f + 1100 + LAT + H_CYC + 20);
    check("nto_queue_empty", 64'(exp_q.size()), 64'(0));
`endif

    // Async reset in the middle of HIGH, then a clean restart.
    en = 1'b1;
    f  = cyc + 1;
    push(EV_FALL, f);
    push(EV_CHG, f + 25);
    push(EV_RISE, f + L_CYC + LAT);
    wait_cyc(f + 60);
    rst_n = 1'b0;
    #1;
    check("arst_scl_oe", 64'(scl_oe), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    wait_cyc(f + 65);
    rst_n = 1'b1;
    push_period(f + 66, 1'b1);
    wait_cyc(f + 66);
    check("restart_oe", 64'(scl_oe), 64'(1));
    wait_cyc(f + 66 + 80);
    en = 1'b0;
    wait_cyc(f + 66 + 103 + 50);
    check("restart_busy", 64'(busy), 64'(0));
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_scl_sched.md
Name: i2c_scl_sched

Overview:
- Synthesizable SCL timing scheduler for the I2C master; the hardware counterpart of the bench clock generator.
- Builds SCL low/high phases from the system clock using a cycle counter. Honours slave clock stretching.
- Emits single-cycle phase strobes that the bit/byte engine uses to change SDA and sample SDA.

Parameters:
- CLK_FREQ_KHZ, 100000, system clock frequency in kHz.
- SCL_FREQ_KHZ, 100, target SCL frequency in kHz.
- DUTY, 50, SCL high time as a percentage of the period.
- TIMEOUT_CYC, 100000, stretch timeout in clk cycles. Used only with the optional feature.
- Derived: PERIOD=CLK_FREQ_KHZ/SCL_FREQ_KHZ, HIGH_CYC=PERIOD*DUTY/100, LOW_CYC=PERIOD-HIGH_CYC.
- Elaboration error if LOW_CYC<4 or HIGH_CYC<4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  request SCL clocking.
- scl_i  in  1  SCL pad input (asynchronous).
- scl_oe  out  1  1 = drive SCL low, 0 = release (open drain).
- fall_stb  out  1  pulse: SCL driven low this cycle.
- chg_stb  out  1  pulse: mid-low, SDA may change.
- rise_stb  out  1  pulse: SCL seen high.
- smp_stb  out  1  pulse: mid-high, sample SDA.
- done  out  1  pulse: clocking finished, SCL left high.
- busy  out  1  state != IDLE.
- stretched  out  1  SCL released but still held low externally.
- timeout  out  1  pulse: stretch timeout. Tied 0 without the macro.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, cnt=0, scl_oe=0, all strobes and done 0, busy=0, stretched=0, synchronizer flops=1.
- scl_i passes a 2-flop synchronizer before use (scl_s). This adds 2 cycles of latency.
- All outputs are registered. Strobes are one cycle wide.
- IDLE: en=1 -> LOW, scl_oe=1, fall_stb=1, cnt=0. en=0 -> stay in IDLE.
- LOW:
  - cnt increments each cycle.
  - chg_stb when cnt==LOW_CYC/2.
  - At cnt==LOW_CYC-1 -> WAIT_HIGH, scl_oe=0.
- WAIT_HIGH:
  - scl_s=1 -> HIGH, cnt=0, rise_stb=1.
  - Otherwise stay, with stretched=1 from the second WAIT_HIGH cycle onward, to allow for synchronizer latency.
  - Stretch time does not count toward HIGH_CYC.
- HIGH:
  - smp_stb when cnt==HIGH_CYC/2.
  - At cnt==HIGH_CYC-1: en=1 -> LOW with fall_stb and scl_oe=1.
  - At cnt==HIGH_CYC-1: en=0 -> IDLE with done=1 and scl_oe=0.
- en is sampled only in IDLE and at the last HIGH cycle. Deasserting en mid-period always completes the current period, so SCL never truncates.
- scl_s going low during HIGH (another master) is ignored. Arbitration is not handled in this block.
- Reset mid-operation: immediate IDLE, SCL released. No done pulse.
- cnt width is $clog2(PERIOD)+1. cnt never wraps, because every compare terminates it.

Optional Feature:
- Macro: I2C_SCL_STRETCH_TIMEOUT_EN.
- Defined:
  - A stretch counter runs in WAIT_HIGH and clears on exit.
  - When it reaches TIMEOUT_CYC-1: timeout=1 for one cycle, state -> IDLE, scl_oe=0, no done pulse.
- Undefined:
  - No counter. WAIT_HIGH waits indefinitely.
  - timeout is tied 0.

Decomposition:
- Shared package i2c_pkg holds:
  - The state enum (IDLE, LOW, WAIT_HIGH, HIGH).
  - A constant function that computes LOW_CYC/HIGH_CYC from the parameters. The bit/byte engine reuses it.
- One sub-module, sync_2ff, for scl_i. It is reused later for SDA.

Test Plan:
- Common settings: CLK_FREQ_KHZ=100000, SCL_FREQ_KHZ=1000, DUTY=50 (PERIOD=100, LOW=50, HIGH=50). Loopback scl_i = !scl_oe unless stated.
- Reset: hold rst_n=0 with en=1 -> scl_oe=0, busy=0, no strobes. Release with en=0 -> remains IDLE for 200 cycles.
- 3 periods: en=1 -> fall_stb at cycle 0, chg_stb at 25, scl_oe=0 at 50, rise_stb 2–3 cycles later, smp_stb 25 cycles after rise_stb. Each low phase is exactly 50 cycles.
- Stop: drop en at cycle 20 of period 2 -> period 2 completes, done pulses once, scl_oe=0, busy=0. No further fall_stb.
- Stretch: hold scl_i=0 for 200 cycles after release -> stretched=1, rise_stb only after scl_i goes high, then a full 50-cycle HIGH.
- Timeout (macro defined, TIMEOUT_CYC=1000): scl_i stuck at 0 -> timeout pulse exactly once after 1000 WAIT_HIGH cycles, state IDLE. Macro undefined: no timeout, busy stays 1.
- Async reset mid-HIGH -> scl_oe=0 and busy=0 immediately, no done. A subsequent en=1 restarts cleanly with fall_stb.
